// File: rtl/floor_request_sched_if.sv
// Button-panel / motion-controller bundle for floor_request_sched.
// The scheduler uses the slave modport; the panel/controller side uses the master modport.
interface floor_request_sched_if #(
    parameter int unsigned FLOORS = 4,
    parameter int unsigned FW     = 2
);
    logic [FLOORS-1:0] set_dest;
    logic              ce;
    logic [FW-1:0]     cur_Floor;
    logic [FLOORS-1:0] get_dest;
    logic [1:0]        dir;
    logic [FW-1:0]     target;
    logic              target_valid;
    logic              stop_here;

    modport master (
        output set_dest, ce, cur_Floor,
        input  get_dest, dir, target, target_valid, stop_here
    );

    modport slave (
        input  set_dest, ce, cur_Floor,
        output get_dest, dir, target, target_valid, stop_here
    );
endinterface

// File: rtl/floor_request_sched.sv
// Car-call request latch with an UP/DOWN/IDLE sweep scheduler reporting the next target floor.
// Define REQ_CANCEL_EN for edge-detected buttons where a second press cancels a pending call.
module floor_request_sched #(
    parameter int unsigned FLOORS = 4,
    parameter int unsigned FW     = 2
) (
    input logic                  clk,
    input logic                  rst,
    floor_request_sched_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StUp   = 2'b01,
        StDown = 2'b10
    } dir_e;

    dir_e              state_q, state_d;
    logic [FLOORS-1:0] req_q, req_d;
    logic [31:0]       cur_idx;
    logic              in_range;
    logic              above, below, stop;

    assign cur_idx  = 32'(bus.cur_Floor);
    assign in_range = cur_idx < FLOORS;

    // An out-of-range floor sits above every real floor: everything pending is below.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        stop  = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (req_q[i]) begin
                if (!in_range || i < cur_idx) begin
                    below = 1'b1;
                end else if (i > cur_idx) begin
                    above = 1'b1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

`ifdef REQ_CANCEL_EN
    logic [FLOORS-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '1;
        end else begin
            prev_q <= bus.set_dest;
        end
    end

    always_comb begin
        req_d = req_q;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (bus.ce && in_range && cur_idx == i) begin
                req_d[i] = 1'b0;
            end else if (prev_q[i] && !bus.set_dest[i]) begin
                req_d[i] = !req_q[i];
            end
        end
    end
`else
    always_comb begin
        req_d = req_q;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (bus.ce && in_range && cur_idx == i) begin
                req_d[i] = 1'b0;
            end else if (!bus.set_dest[i]) begin
                req_d[i] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            state_q <= StIdle;
        end else begin
            req_q   <= req_d;
            state_q <= state_d;
        end
    end

    // IDLE and UP share the same preference order, so a tie from IDLE goes up.
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle, StUp: begin
                if (above) begin
                    state_d = StUp;
                end else if (below) begin
                    state_d = StDown;
                end
            end
            StDown: begin
                if (below) begin
                    state_d = StDown;
                end else if (above) begin
                    state_d = StUp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // UP scans downwards so the lowest floor above wins; DOWN scans upwards for the highest below.
    always_comb begin
        bus.target = bus.cur_Floor;
        if (state_q == StUp) begin
            for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
                if (req_q[i] && in_range && 32'(i) > cur_idx) begin
                    bus.target = FW'(i);
                end
            end
        end else if (state_q == StDown) begin
            for (int unsigned i = 0; i < FLOORS; i++) begin
                if (req_q[i] && (!in_range || i < cur_idx)) begin
                    bus.target = FW'(i);
                end
            end
        end
    end

    assign bus.get_dest     = req_q;
    assign bus.dir          = state_q;
    assign bus.stop_here    = stop;
    assign bus.target_valid = (state_q == StUp && above) || (state_q == StDown && below);

endmodule

// File: tb/tb_floor_request_sched.sv
// Directed and randomized check of floor_request_sched against an arithmetic reference model.
module tb_floor_request_sched;

    localparam int unsigned FLOORS = 4;
    localparam int unsigned FW     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    floor_request_sched_if #(.FLOORS(FLOORS), .FW(FW)) bus ();

    floor_request_sched #(.FLOORS(FLOORS), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit pend[FLOORS];
    bit prev[FLOORS];
    int mdir = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain arithmetic over the pending set; out-of-range floors fall out naturally.
    function automatic void m_derive(input int cf, output bit ab, output bit be, output bit st,
                                     output int tg, output bit tv);
        int lo_above = -1;
        int hi_below = -1;
        for (int j = 0; j < int'(FLOORS); j++) begin
            if (pend[j] && j > cf && lo_above < 0) lo_above = j;
            if (pend[j] && j < cf) hi_below = j;
        end
        ab = lo_above >= 0;
        be = hi_below >= 0;
        st = cf < int'(FLOORS) && pend[cf];
        if (mdir == 1) tg = lo_above;
        else if (mdir == 2) tg = hi_below;
        else tg = cf;
        tv = (mdir == 1 && ab) || (mdir == 2 && be);
    endfunction

    function automatic void m_clock(input bit r, input logic [FLOORS-1:0] sd, input bit c,
                                    input int cf);
        bit ab, be, st, tv;
        int tg;
        m_derive(cf, ab, be, st, tg, tv);
        if (r) begin
            for (int j = 0; j < int'(FLOORS); j++) begin
                pend[j] = 0;
                prev[j] = 1;
            end
            mdir = 0;
            return;
        end
        if (mdir == 2) mdir = be ? 2 : (ab ? 1 : 0);
        else mdir = ab ? 1 : (be ? 2 : 0);
        for (int j = 0; j < int'(FLOORS); j++) begin
`ifdef REQ_CANCEL_EN
            if (c && cf == j) pend[j] = 0;
            else if (prev[j] && !sd[j]) pend[j] = !pend[j];
            prev[j] = sd[j];
`else
            if (c && cf == j) pend[j] = 0;
            else if (!sd[j]) pend[j] = 1;
`endif
        end
    endfunction

    // Called at a falling edge: apply inputs, compare, clock the model, return at next falling edge.
    task automatic step(input bit r, input logic [FLOORS-1:0] sd, input bit c, input int cf);
        bit ab, be, st, tv;
        int tg;
        logic [FLOORS-1:0] mask;
        rst           = r;
        bus.set_dest  = sd;
        bus.ce        = c;
        bus.cur_Floor = FW'(cf);
        #1;
        m_derive(cf, ab, be, st, tg, tv);
        for (int j = 0; j < int'(FLOORS); j++) mask[j] = pend[j];
        check("get_dest", 32'(bus.get_dest), 32'(mask));
        check("dir", 32'(bus.dir), 32'(mdir));
        check("stop_here", 32'(bus.stop_here), 32'(st));
        check("target_valid", 32'(bus.target_valid), 32'(tv));
        if (mdir == 0 || tv) check("target", 32'(bus.target), 32'(tg));
        @(posedge clk);
        m_clock(r, sd, c, cf);
        @(negedge clk);
    endtask

    initial begin
        logic [FLOORS-1:0] sd;
        bus.set_dest  = '1;
        bus.ce        = 1'b0;
        bus.cur_Floor = '0;
        @(negedge clk);
        m_clock(1, '1, 0, 0);

        // Reset with all buttons pressed
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        check("rst_mask", 32'(bus.get_dest), 32'h0);
        check("rst_dir", 32'(bus.dir), 32'h0);
        check("rst_valid", 32'(bus.target_valid), 32'h0);

        // Press floor 2 from floor 0
        step(0, 4'b1011, 0, 0);
        check("press_lat", 32'(bus.get_dest), 32'h4);
        check("press_dir_wait", 32'(bus.dir), 32'h0);
        step(0, 4'b1111, 0, 0);
        check("press_dir", 32'(bus.dir), 32'h1);
        check("press_target", 32'(bus.target), 32'h2);
        check("press_valid", 32'(bus.target_valid), 32'h1);

        // Button held at the floor being serviced
        for (int k = 0; k < 3; k++) begin
            step(0, 4'b1101, 1, 1);
            check("collide_clr", 32'(bus.get_dest[1]), 32'h0);
        end

        // Sweep hold then reversal
        step(1, 4'b1111, 0, 2);
        step(0, 4'b0110, 0, 2);
        step(0, 4'b1111, 0, 2);
        step(0, 4'b1111, 0, 2);
        check("sweep_up", 32'(bus.dir), 32'h1);
        check("sweep_target", 32'(bus.target), 32'h3);
        step(0, 4'b1111, 1, 3);
        check("sweep_mask", 32'(bus.get_dest), 32'h1);
        step(0, 4'b1111, 0, 3);
        check("sweep_down", 32'(bus.dir), 32'h2);
        check("sweep_target_dn", 32'(bus.target), 32'h0);

        // Reset mid-travel
        step(1, 4'b1111, 0, 0);
        step(0, 4'b0101, 0, 0);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 0, 0);
        check("mid_dir", 32'(bus.dir), 32'h1);
        step(1, 4'b0111, 0, 0);
        check("mid_rst_mask", 32'(bus.get_dest), 32'h0);
        check("mid_rst_dir", 32'(bus.dir), 32'h0);
        check("mid_rst_valid", 32'(bus.target_valid), 32'h0);

`ifdef REQ_CANCEL_EN
        step(0, 4'b1111, 0, 0);
        step(0, 4'b0111, 0, 0);
        check("cancel_set", 32'(bus.get_dest[3]), 32'h1);
        step(0, 4'b0111, 0, 0);
        check("cancel_hold", 32'(bus.get_dest[3]), 32'h1);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b0111, 0, 0);
        check("cancel_clr", 32'(bus.get_dest[3]), 32'h0);
`endif

        // Randomized traffic, including out-of-range floors
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < int'(FLOORS); j++) sd[j] = ($urandom_range(0, 4) != 0);
            step(($urandom_range(0, 49) == 0), sd, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7))
                                             : int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
